exec_unit: RTL and testbench

Parametrised RV32I/RV32M execute unit replacing the purely combinational ALU-plus-control pair in the execute stage. It uses the same `alu_op`/`funct7`/`funct3` decode as the existing ALU. Base integer ops complete in one cycle; M-extension multiply and divide run iteratively over `XLEN` cycles. Results leave through a registered valid/ready output so the pipeline can stall on long ops.

---
 rtl/exec_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_exec_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: execute stage with single-cycle base integer ops and iterative
// M-extension multiply/divide (one bit per cycle) behind a registered
// valid/ready output so the pipeline can stall on long operations.
module exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    localparam logic [SHW-1:0]  LAST_ITER = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t state;
    state_t next_state;

    logic            accept;
    logic            is_m;
    logic            last_iter;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;

    // operand handling at accept time
    logic            sign_a;
    logic            sign_b;
    logic            a_neg_now;
    logic            b_neg_now;
    logic [XLEN-1:0] mag_a_now;
    logic [XLEN-1:0] mag_b_now;

    // state captured at accept for the iterative ops
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   mag_op;
    logic [2*XLEN-1:0] acc;
    logic [2:0]        m_f3;
    logic              neg_a;
    logic              neg_b;
    logic              div_zero;
    logic              div_ovf;
    logic [SHW-1:0]    cnt;

    // per-iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] mul_fixed;
    logic [XLEN-1:0]   mul_final;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   div_rem_next;
    logic [XLEN-1:0]   div_quo_next;
    logic [XLEN-1:0]   quo_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   div_final;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_m      = (alu_op == 2'b10) && (funct7 == 7'b0000001);
    assign last_iter = (cnt == LAST_ITER);
    assign shamt     = b[SHW-1:0];
    assign busy      = (state == MUL) || (state == DIV);

    // Single-cycle base ALU; funct7[5] only picks SUB for R-type and SRA for both forms
    always_comb begin
        base_res = '0;
        if (alu_op == 2'b00) begin
            base_res = a + b;
        end else if (alu_op == 2'b01) begin
            base_res = a - b;
        end else begin
            case (funct3)
                3'b000: begin
                    if ((alu_op == 2'b10) && funct7[5]) begin
                        base_res = a - b;
                    end else begin
                        base_res = a + b;
                    end
                end
                3'b001: base_res = a << shamt;
                3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                3'b011: base_res = {{(XLEN-1){1'b0}}, (a < b)};
                3'b100: base_res = a ^ b;
                3'b101: begin
                    if (funct7[5]) begin
                        base_res = $unsigned($signed(a) >>> shamt);
                    end else begin
                        base_res = a >> shamt;
                    end
                end
                3'b110: base_res = a | b;
                default: base_res = a & b;
            endcase
        end
    end

    // Operand signedness per M op, and magnitudes fed to the unsigned iterators
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                sign_a = 1'b1;
                sign_b = 1'b1;
            end
            3'b010: sign_a = 1'b1;
            default: begin
                sign_a = 1'b0;
                sign_b = 1'b0;
            end
        endcase
        a_neg_now = sign_a & a[XLEN-1];
        b_neg_now = sign_b & b[XLEN-1];
        mag_a_now = a_neg_now ? -a : a;
        mag_b_now = b_neg_now ? -b : b;
    end

    // One shift-add / restoring-divide step plus the final sign and special-case fix-up
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_op} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        mul_fixed = (neg_a ^ neg_b) ? -mul_next : mul_next;
        mul_final = (m_f3 == 3'b000) ? mul_fixed[XLEN-1:0] : mul_fixed[2*XLEN-1:XLEN];

        div_shift    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge       = div_shift >= {1'b0, mag_op};
        div_diff     = div_shift[XLEN-1:0] - mag_op;
        div_rem_next = div_ge ? div_diff : div_shift[XLEN-1:0];
        div_quo_next = {acc[XLEN-2:0], div_ge};
        quo_signed   = (neg_a ^ neg_b) ? -div_quo_next : div_quo_next;
        rem_signed   = neg_a ? -div_rem_next : div_rem_next;
        if (div_zero) begin
            quo_signed = '1;
            rem_signed = op_a;
        end else if (div_ovf) begin
            quo_signed = MOST_NEG;
            rem_signed = '0;
        end
        div_final = m_f3[1] ? rem_signed : quo_signed;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: M ops leave IDLE, iterations return after exactly XLEN cycles
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && is_m) begin
                    next_state = funct3[2] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (last_iter) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture operands at accept, then advance the multiply/divide accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            mag_op   <= '0;
            acc      <= '0;
            m_f3     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            cnt      <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (accept && is_m) begin
                op_a     <= a;
                m_f3     <= funct3;
                neg_a    <= a_neg_now;
                neg_b    <= b_neg_now;
                div_zero <= funct3[2] && (b == '0);
                div_ovf  <= funct3[2] && !funct3[0] && (a == MOST_NEG) && (b == '1);
                if (funct3[2]) begin
                    mag_op <= mag_b_now;
                    acc    <= {{XLEN{1'b0}}, mag_a_now};
                end else begin
                    mag_op <= mag_a_now;
                    acc    <= {{XLEN{1'b0}}, mag_b_now};
                end
            end
        end else begin
            cnt <= cnt + 1'b1;
            if (state == MUL) begin
                acc <= mul_next;
            end else begin
                acc <= {div_rem_next, div_quo_next};
            end
        end
    end

    // Output register: drains on handshake, refilled by a base op or a finished iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !is_m) begin
                out_valid <= 1'b1;
                result    <= base_res;
                zero      <= (base_res == '0);
            end else if ((state == MUL) && last_iter) begin
                out_valid <= 1'b1;
                result    <= mul_final;
                zero      <= (mul_final == '0);
            end else if ((state == DIV) && last_iter) begin
                out_valid <= 1'b1;
                result    <= div_final;
                zero      <= (div_final == '0);
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit: directed vectors on a 32-bit and a 64-bit instance,
// expected results queued at accept and checked by output monitors.
`timescale 1ns/1ps
module tb_exec_unit;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;
    localparam logic [6:0] F7_0   = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_M   = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid32;
    logic        in_valid64;
    logic        in_ready32;
    logic        in_ready64;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        out_valid32;
    logic        out_valid64;
    logic        out_ready;
    logic [31:0] result32;
    logic [63:0] result64;
    logic        zero32;
    logic        zero64;
    logic        busy32;
    logic        busy64;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic [63:0] exp32_q[$];
    logic [63:0] exp64_q[$];
    string       name32_q[$];
    string       name64_q[$];
    logic [63:0] e32;
    logic [63:0] e64;
    string       n32;
    string       n64;

    exec_unit #(.XLEN(32)) dut32 (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid32),
        .in_ready(in_ready32),
        .a(a[31:0]),
        .b(b[31:0]),
        .alu_op(alu_op),
        .funct7(funct7),
        .funct3(funct3),
        .out_valid(out_valid32),
        .out_ready(out_ready),
        .result(result32),
        .zero(zero32),
        .busy(busy32)
    );

    exec_unit #(.XLEN(64)) dut64 (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid64),
        .in_ready(in_ready64),
        .a(a),
        .b(b),
        .alu_op(alu_op),
        .funct7(funct7),
        .funct3(funct3),
        .out_valid(out_valid64),
        .out_ready(out_ready),
        .result(result64),
        .zero(zero64),
        .busy(busy64)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one request and hold it until accepted; queue its expected result
    task automatic applyStimulus(input bit w64, input logic [1:0] op, input logic [6:0] f7,
                                 input logic [2:0] f3, input logic [63:0] av, input logic [63:0] bv,
                                 input logic [63:0] exp, input string nm, input bit push);
        int waited;
        waited = 0;
        alu_op = op;
        funct7 = f7;
        funct3 = f3;
        a = av;
        b = bv;
        if (w64) in_valid64 = 1'b1;
        else in_valid32 = 1'b1;
        @(negedge clk);
        while (!(w64 ? in_ready64 : in_ready32) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!(w64 ? in_ready64 : in_ready32)) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_accept: in_ready stayed 0, expected 1 within 200 cycles", nm);
        end else begin
            accept_cyc = cyc;
            if (push) begin
                if (w64) begin
                    exp64_q.push_back(exp);
                    name64_q.push_back(nm);
                end else begin
                    exp32_q.push_back(exp);
                    name32_q.push_back(nm);
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
    endtask

    // Wait for out_valid (bounded) and compare cycles elapsed since accept
    task automatic checkLatency(input bit w64, input int lat, input string nm);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(w64 ? out_valid64 : out_valid32) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({nm, "_latency"}, 64'(cyc - accept_cyc), 64'(lat));
        @(posedge clk);
        #1;
    endtask

    task automatic mOp(input bit w64, input logic [2:0] f3, input logic [63:0] av,
                       input logic [63:0] bv, input logic [63:0] exp, input string nm, input int lat);
        applyStimulus(w64, OP_R, F7_M, f3, av, bv, exp, nm, 1'b1);
        checkLatency(w64, lat, nm);
    endtask

    // 32-bit monitor: every handshake pops and compares the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid32 && out_ready) begin
            if (exp32_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out32: got result %h, expected no output", result32);
            end else begin
                e32 = exp32_q.pop_front();
                n32 = name32_q.pop_front();
                checkOutput({n32, "_result"}, {32'b0, result32}, e32);
                checkOutput({n32, "_zero"}, {63'b0, zero32}, {63'b0, (e32 == 64'd0)});
            end
        end
    end

    // 64-bit monitor
    always @(negedge clk) begin
        if (!rst && out_valid64 && out_ready) begin
            if (exp64_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out64: got result %h, expected no output", result64);
            end else begin
                e64 = exp64_q.pop_front();
                n64 = name64_q.pop_front();
                checkOutput({n64, "_result"}, result64, e64);
                checkOutput({n64, "_zero"}, {63'b0, zero64}, {63'b0, (e64 == 64'd0)});
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int n;
        int first_acc;
        int bad;
        int waited;

        rst = 1'b1;
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
        a = 64'd0;
        b = 64'd0;
        alu_op = OP_ADD;
        funct7 = F7_0;
        funct3 = 3'b000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_out_valid", {63'b0, out_valid32}, 64'd0);
        checkOutput("rst_result", {32'b0, result32}, 64'd0);
        checkOutput("rst_zero", {63'b0, zero32}, 64'd0);
        checkOutput("rst_busy", {63'b0, busy32}, 64'd0);
        checkOutput("rst_in_ready", {63'b0, in_ready32}, 64'd1);
        checkOutput("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, OP_SUB, F7_0, 3'b000, 64'd5, 64'd5, 64'd0, "sub_eq", 1'b1);
        first_acc = accept_cyc;
        applyStimulus(1'b0, OP_ADD, F7_0, 3'b000, 64'hFFFF_FFFF, 64'd1, 64'd0, "add_wrap", 1'b1);
        checkOutput("throughput", 64'(accept_cyc - first_acc), 64'd1);
        applyStimulus(1'b0, OP_I, F7_ALT, 3'b101, 64'h8000_0000, 64'd4, 64'hF800_0000, "srai", 1'b1);
        applyStimulus(1'b0, OP_I, F7_0, 3'b101, 64'h8000_0000, 64'd4, 64'h0800_0000, "srli", 1'b1);
        applyStimulus(1'b0, OP_R, F7_ALT, 3'b000, 64'd10, 64'd3, 64'd7, "sub_r", 1'b1);
        applyStimulus(1'b0, OP_I, F7_ALT, 3'b000, 64'd10, 64'd3, 64'd13, "addi_f7", 1'b1);
        applyStimulus(1'b0, OP_R, F7_0, 3'b001, 64'd1, 64'h24, 64'h10, "sll_mask", 1'b1);
        applyStimulus(1'b0, OP_R, F7_0, 3'b010, 64'hFFFF_FFFF, 64'd1, 64'd1, "slt", 1'b1);
        applyStimulus(1'b0, OP_R, F7_0, 3'b011, 64'hFFFF_FFFF, 64'd1, 64'd0, "sltu", 1'b1);
        applyStimulus(1'b0, OP_R, F7_0, 3'b100, 64'hF0F0, 64'hFF00, 64'h0FF0, "xor", 1'b1);
        applyStimulus(1'b0, OP_R, F7_0, 3'b110, 64'hF0, 64'h0F, 64'hFF, "or", 1'b1);
        applyStimulus(1'b0, OP_I, F7_0, 3'b111, 64'hF0, 64'h3C, 64'h30, "andi", 1'b1);
        applyStimulus(1'b0, OP_ADD, F7_0, 3'b000, 64'd2, 64'd3, 64'd5, "add", 1'b1);
        checkLatency(1'b0, 1, "add");

        applyStimulus(1'b0, OP_R, F7_M, 3'b001, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, "mulh", 1'b1);
        n = accept_cyc;
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (!(busy32 && !in_ready32 && !out_valid32)) bad++;
            a = {32'd0, $urandom};
            b = {32'd0, $urandom};
        end
        checkOutput("mulh_busy_window", 64'(bad), 64'd0);
        @(negedge clk);
        checkOutput("mulh_valid_at_33", {63'b0, out_valid32}, 64'd1);
        checkOutput("mulh_cycle", 64'(cyc - n), 64'd33);
        @(posedge clk);
        #1;

        mOp(1'b0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, "mulhu", 33);
        mOp(1'b0, 3'b000, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, "mul", 33);
        mOp(1'b0, 3'b010, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF, "mulhsu", 33);
        mOp(1'b0, 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, "div_neg", 33);
        mOp(1'b0, 3'b110, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, "rem_neg", 33);
        mOp(1'b0, 3'b101, 64'h1234, 64'd0, 64'hFFFF_FFFF, "divu_zero", 33);
        mOp(1'b0, 3'b110, 64'd9, 64'd0, 64'd9, "rem_zero", 33);
        mOp(1'b0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, "div_ovf", 33);
        mOp(1'b0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, "rem_ovf", 33);
        mOp(1'b0, 3'b101, 64'd100, 64'd7, 64'd14, "divu", 33);
        mOp(1'b0, 3'b111, 64'd100, 64'd7, 64'd2, "remu", 33);

        out_ready = 1'b0;
        applyStimulus(1'b0, OP_ADD, F7_0, 3'b000, 64'd2, 64'd3, 64'd5, "bp_first", 1'b1);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (!(out_valid32 && (result32 == 32'd5) && !zero32 && !in_ready32)) bad++;
        end
        checkOutput("bp_hold", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(1'b0, OP_R, F7_0, 3'b100, 64'hF0, 64'hFF, 64'h0F, "bp_second", 1'b1);
        n = accept_cyc;
        @(negedge clk);
        checkOutput("bp_no_bubble_valid", {63'b0, out_valid32}, 64'd1);
        checkOutput("bp_no_bubble_result", {32'b0, result32}, 64'h0F);
        checkOutput("bp_no_bubble_cycle", 64'(cyc - n), 64'd1);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, OP_R, F7_M, 3'b100, 64'd100, 64'd7, 64'd0, "aborted_div", 1'b0);
        n = accept_cyc;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {63'b0, busy32}, 64'd0);
        checkOutput("abort_out_valid", {63'b0, out_valid32}, 64'd0);
        checkOutput("abort_cycle", 64'(cyc - n), 64'd11);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid32 = 1'b1;
        alu_op = OP_ADD;
        a = 64'd1;
        b = 64'd1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid32 = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid32 || busy32) bad++;
        end
        checkOutput("no_partial_result", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, OP_ADD, F7_0, 3'b000, 64'd40, 64'd2, 64'd42, "add_after_rst", 1'b1);
        checkLatency(1'b0, 1, "add_after_rst");

        mOp(1'b1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE, "mulhu64", 65);
        mOp(1'b1, 3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            64'h4000_0000_0000_0000, "mulh64", 65);
        mOp(1'b1, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div64", 65);
        mOp(1'b1, 3'b110, 64'd9, 64'd0, 64'd9, "rem_zero64", 65);
        applyStimulus(1'b1, OP_ADD, F7_0, 3'b000, 64'hFFFF_FFFF, 64'd1, 64'h1_0000_0000, "add64", 1'b1);
        checkLatency(1'b1, 1, "add64");

        waited = 0;
        while ((exp32_q.size() != 0 || exp64_q.size() != 0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard_drained", 64'(exp32_q.size() + exp64_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
